// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory pipeline stage and its load extender.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned T_W    = 4;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [T_W-1:0]   t;
    logic             wre;
    logic [REG_W-1:0] reg_id;
    logic [XLEN-1:0]  data;
  } m_regs_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// Selects the addressed byte/half of a load response and sign- or zero-extends it.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {offset, 3'b000});
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LT_LB:   data_c = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_c = {24'b0, byte_sel};
      LT_LH:   data_c = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data_c = {16'b0, half_sel};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one SRAM-like transaction per load/store, stalls E
// until the response, and drains responses orphaned by an exception flush.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              Clk,
  input  logic              Clr,
  input  logic              exp_flush,
  input  logic [XLEN-1:0]   E_PC,
  input  logic              E_MemRead,
  input  logic [STRB_W-1:0] E_MemWriteEnable,
  input  logic [XLEN-1:0]   E_calLSaddr,
  input  logic [XLEN-1:0]   E_WriteMemData,
  input  logic [2:0]        E_LoadType,
  input  logic              E_data_alignment_err,
  input  logic [T_W-1:0]    E_T,
  input  logic              E_WriteRegEnable,
  input  logic [REG_W-1:0]  E_RegId,
  input  logic [XLEN-1:0]   E_Data,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [XLEN-1:0]   data_sram_addr,
  output logic [XLEN-1:0]   data_sram_wdata,
  output logic [STRB_W-1:0] data_sram_wstrb,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [XLEN-1:0]   data_sram_rdata,
  output logic              dm_stall,
  output logic [XLEN-1:0]   M_PC,
  output logic [T_W-1:0]    M_T,
  output logic              M_WriteRegEnable,
  output logic [REG_W-1:0]  M_RegId,
  output logic [XLEN-1:0]   M_Data
);

  state_e          state;
  state_e          state_next;
  logic            is_store_c;
  logic            memop_c;
  logic            wait_done_c;
  logic [XLEN-1:0] ext_data;
  m_regs_t         m_q;
  m_regs_t         m_next;

  mem_stage_load_ext load_ext (
    .rdata     (data_sram_rdata),
    .offset    (E_calLSaddr[1:0]),
    .load_type (E_LoadType),
    .data_c    (ext_data)
  );

  // State register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (data_sram_req && data_sram_addr_ok) state_next = ST_WAIT;
      ST_WAIT:  if (data_sram_data_ok) state_next = ST_IDLE;
                else if (exp_flush)    state_next = ST_DRAIN;
      ST_DRAIN: if (data_sram_data_ok) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request and stall outputs; held low while reset is asserted
  always_comb begin
    is_store_c      = |E_MemWriteEnable;
    memop_c         = (E_MemRead | is_store_c) & ~E_data_alignment_err & ~exp_flush;
    wait_done_c     = (state == ST_WAIT) & data_sram_data_ok;
    data_sram_req   = Clr & memop_c & (state == ST_IDLE);
    data_sram_wr    = Clr & is_store_c;
    data_sram_wstrb = Clr ? E_MemWriteEnable : '0;
    data_sram_addr  = E_calLSaddr;
    dm_stall        = Clr & memop_c & ~wait_done_c;
    data_sram_size  = SIZE_WORD;
    if (is_store_c) begin
      case (E_MemWriteEnable)
        4'b1111:          data_sram_size = SIZE_WORD;
        4'b0011, 4'b1100: data_sram_size = SIZE_HALF;
        default:          data_sram_size = SIZE_BYTE;
      endcase
    end else begin
      case (E_LoadType)
        LT_LB, LT_LBU: data_sram_size = SIZE_BYTE;
        LT_LH, LT_LHU: data_sram_size = SIZE_HALF;
        default:       data_sram_size = SIZE_WORD;
      endcase
    end
    case (data_sram_size)
      SIZE_BYTE: data_sram_wdata = {4{E_WriteMemData[7:0]}};
      SIZE_HALF: data_sram_wdata = {2{E_WriteMemData[15:0]}};
      default:   data_sram_wdata = E_WriteMemData;
    endcase
  end

  // A load only retires when its response arrives in WAIT, so ext_data is valid then
  always_comb begin
    m_next.pc     = E_PC;
    m_next.t      = (E_T == '0) ? '0 : E_T - T_W'(1);
    m_next.wre    = E_WriteRegEnable;
    m_next.reg_id = E_RegId;
    m_next.data   = (E_MemRead & ~E_data_alignment_err) ? ext_data : E_Data;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)          m_q <= '0;
    else if (exp_flush) m_q <= '0;
    else if (!dm_stall) m_q <= m_next;
  end

  assign M_PC             = m_q.pc;
  assign M_T              = m_q.t;
  assign M_WriteRegEnable = m_q.wre;
  assign M_RegId          = m_q.reg_id;
  assign M_Data           = m_q.data;

endmodule
